// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter.
//   state_e       : arbiter FSM states
//   OWN_IF/OWN_D  : owner encodings (also the address/write-data mux select)
//   DEF_MAX_BURST : default limit on back-to-back data grants while fetch waits
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/Mux32Bit2To1.sv
// Plain 2:1 word multiplexer.
//   Sel : 0 selects In0, 1 selects In1
//   In0 / In1 : data inputs
//   Out : selected word
module Mux32Bit2To1 #(
  parameter int WIDTH = 32
) (
  input  logic             Sel,
  input  logic [WIDTH-1:0] In0,
  input  logic [WIDTH-1:0] In1,
  output logic [WIDTH-1:0] Out
);

  assign Out = Sel ? In1 : In0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data memory.
// One transaction at a time: IDLE (grant) -> ACCESS (wait mem_ready) -> DONE
// (one-cycle ack to the owner). Data has priority, but after MAX_BURST
// consecutive data grants with fetch pending, fetch is granted once.
//   Clk, Rst        : clock, async active-low reset
//   if_req/if_addr  : fetch request in; if_ack/if_rdata out
//   d_req/d_we/d_addr/d_wdata : data request in; d_ack/d_rdata out
//   mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ready in : memory port
//   owner           : current/last owner (0 fetch, 1 data), mux select
//   busy            : FSM not in IDLE
// All outputs come straight from flops.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              owner,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;

  logic              grant_vld;
  logic              grant_sel;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  // Arbitration: who wins this IDLE cycle and how the burst counter moves.
  always_comb begin
    grant_vld   = 1'b0;
    grant_sel   = OWN_IF;
    burst_cnt_d = burst_cnt_q;
    if (state_q == IDLE && (if_req || d_req)) begin
      grant_vld = 1'b1;
      if (d_req && (!if_req || burst_cnt_q != BURST_LIM))
        grant_sel = OWN_D;
      // Counter only tracks data grants that made a pending fetch wait.
      if (grant_sel == OWN_D && if_req)
        burst_cnt_d = (burst_cnt_q == BURST_LIM) ? burst_cnt_q
                                                 : burst_cnt_q + CNT_W'(1);
      else
        burst_cnt_d = '0;
    end
  end

  Mux32Bit2To1 #(.WIDTH(ADDR_W)) u_addr_mux (
    .Sel (grant_sel),
    .In0 (if_addr),
    .In1 (d_addr),
    .Out (addr_mux)
  );

  // Fetch never writes, so its write-data leg is tied to zero.
  Mux32Bit2To1 #(.WIDTH(DATA_W)) u_wdata_mux (
    .Sel (grant_sel),
    .In0 ({DATA_W{1'b0}}),
    .In1 (d_wdata),
    .Out (wdata_mux)
  );

  // FSM next-state and registered-output values.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d     = ACCESS;
          owner_d     = grant_sel;
          we_d        = (grant_sel == OWN_D) && d_we;
          mem_addr_d  = addr_mux;
          mem_wdata_d = wdata_mux;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d = DONE;
          if (owner_q == OWN_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = we_q ? '0 : mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Port strobes and busy follow the state being entered, so they are
    // already valid in the first cycle of that state.
    mem_en_d = (state_d == ACCESS);
    mem_we_d = (state_d == ACCESS) && we_d;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign owner     = owner_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;

endmodule
